trace_replay_driver: RTL and testbench

- Parametrised successor to the fixed-length formal trace testbench: replays a stored sequence of per-cycle input vectors ("states") into a miter/DUT.
- Counts cycles, gates a genclock-style run enable, and latches the first cycle on which the miter flags a failure.
- Adds runtime-loadable stimulus, programmable length, loop mode, abort and stop-on-fail.
- Sits between the bench harness (loader/controller) and the miter's input ports.

---
 rtl/trace_pkg.sv | 23 ++
 rtl/trace_mem.sv | 28 ++
 rtl/trace_replay_driver.sv | 187 ++++++++++++++++++
 tb/tb_trace_replay_driver.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types and helpers for the trace replay driver.
package trace_pkg;

  localparam int CYCLE_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v);
    logic [CYCLE_W-1:0] r;
    if (v == {CYCLE_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(CYCLE_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/trace_mem.sv
// Stimulus store: register array, synchronous write, combinational read.
module trace_mem
  import trace_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/trace_replay_driver.sv
// Replays stored per-cycle input vectors into a miter, counting cycles and
// latching the first cycle on which the miter reports a failure.
module trace_replay_driver
  import trace_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 16,
  parameter int STOP_ON_FAIL = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               start,
  input  logic [AW:0]        len,
  input  logic               loop,
  input  logic               abort,
  input  logic               fail,
  output logic [WIDTH-1:0]   stim,
  output logic               stim_valid,
  output logic               genclock,
  output logic [CYCLE_W-1:0] cycle,
  output logic               busy,
  output logic               done,
  output logic               fail_seen,
  output logic [CYCLE_W-1:0] fail_cycle
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1'b1);

  state_t             state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [AW:0]        len_q, len_d;
  logic               loop_q, loop_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic [CYCLE_W-1:0] fail_cycle_q, fail_cycle_d;
  logic [WIDTH-1:0]   stim_q, stim_d;
  logic               stim_valid_q, stim_valid_d;
  logic               genclock_q, genclock_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fail_seen_q, fail_seen_d;

  logic               mem_we_s;
  logic [AW-1:0]      rd_addr_s;
  logic [WIDTH-1:0]   rd_data_s;
  logic [WIDTH-1:0]   rd_word_s;
  logic [AW:0]        len_clamped_s;
  logic               last_s;
  logic               fail_hit_s;

  assign mem_we_s      = wr_en && (state_q == IDLE);
  assign len_clamped_s = (len > DEPTH_L) ? DEPTH_L : len;
  assign last_s        = ({1'b0, idx_q} == (len_q - ONE_L));
  assign fail_hit_s    = fail && stim_valid_q && !fail_seen_q;
  assign rd_addr_s     = ((state_q == RUN) && !last_s) ? (idx_q + AW'(1'b1)) : '0;
  // Forward a same-edge write so start+write to address 0 replays the new word.
  assign rd_word_s     = (mem_we_s && (wr_addr == rd_addr_s)) ? wr_data : rd_data_s;

  trace_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock   (clock),
    .wr_en   (mem_we_s),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  // Next-state and next-output logic for the replay sequencer.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    loop_d       = loop_q;
    cycle_d      = cycle_q;
    stim_d       = stim_q;
    fail_seen_d  = fail_seen_q;
    fail_cycle_d = fail_cycle_q;
    stim_valid_d = 1'b0;
    genclock_d   = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d        = len_clamped_s;
          loop_d       = loop;
          fail_seen_d  = 1'b0;
          fail_cycle_d = '0;
          cycle_d      = '0;
          idx_d        = '0;
          busy_d       = 1'b1;
          if (len_clamped_s == '0) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            state_d      = RUN;
            stim_d       = rd_word_s;
            stim_valid_d = 1'b1;
            genclock_d   = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          if (fail_hit_s) begin
            fail_seen_d  = 1'b1;
            fail_cycle_d = cycle_q;
          end else begin
            fail_seen_d  = fail_seen_q;
          end
          // Fail-stop outranks end-of-length; a failing last state still records.
          if ((fail_hit_s && (STOP_ON_FAIL != 0)) || (last_s && !loop_q)) begin
            state_d = FINISH;
            done_d  = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d      = RUN;
            idx_d        = rd_addr_s;
            cycle_d      = sat_inc(cycle_q);
            stim_d       = rd_word_s;
            stim_valid_d = 1'b1;
            genclock_d   = 1'b1;
            busy_d       = 1'b1;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      loop_q       <= 1'b0;
      cycle_q      <= '0;
      stim_q       <= '0;
      stim_valid_q <= 1'b0;
      genclock_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_seen_q  <= 1'b0;
      fail_cycle_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      loop_q       <= loop_d;
      cycle_q      <= cycle_d;
      stim_q       <= stim_d;
      stim_valid_q <= stim_valid_d;
      genclock_q   <= genclock_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_seen_q  <= fail_seen_d;
      fail_cycle_q <= fail_cycle_d;
    end
  end

  assign stim       = stim_q;
  assign stim_valid = stim_valid_q;
  assign genclock   = genclock_q;
  assign cycle      = cycle_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail_seen  = fail_seen_q;
  assign fail_cycle = fail_cycle_q;

endmodule

// File: tb/tb_trace_replay_driver.sv
// Directed bench: dut_a stops on fail, dut_b continues; a scoreboard checks dut_a's stream.
module tb_trace_replay_driver;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, wr_en, start_a, start_b, loop, abort, fail_a, fail_b;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [4:0]  len;

  logic [7:0]  stim_a, stim_b;
  logic        stim_valid_a, stim_valid_b, genclock_a, genclock_b;
  logic        busy_a, busy_b, done_a, done_b, fail_seen_a, fail_seen_b;
  logic [31:0] cycle_a, cycle_b, fail_cycle_a, fail_cycle_b;

  trace_replay_driver #(.WIDTH(8), .DEPTH(16), .STOP_ON_FAIL(1)) dut_a (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start_a), .len(len), .loop(loop), .abort(abort), .fail(fail_a),
    .stim(stim_a), .stim_valid(stim_valid_a), .genclock(genclock_a), .cycle(cycle_a),
    .busy(busy_a), .done(done_a), .fail_seen(fail_seen_a), .fail_cycle(fail_cycle_a)
  );

  trace_replay_driver #(.WIDTH(8), .DEPTH(16), .STOP_ON_FAIL(0)) dut_b (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start_b), .len(len), .loop(loop), .abort(abort), .fail(fail_b),
    .stim(stim_b), .stim_valid(stim_valid_b), .genclock(genclock_b), .cycle(cycle_b),
    .busy(busy_b), .done(done_b), .fail_seen(fail_seen_b), .fail_cycle(fail_cycle_b)
  );

  typedef struct packed {
    logic [7:0]  stim;
    logic [31:0] cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem_m [16];
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_run(input int n, input int len_eff);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{stim: mem_m[i % len_eff], cyc: i});
    end
  endtask

  task automatic start_run(input logic [4:0] l, input logic lp);
    len = l; loop = lp; start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic run_until_idle(output int bc, output int dc);
    bc = 0; dc = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy_a) bc++;
      if (done_a) dc++;
      if (!busy_a) break;
      step();
    end
    chk("idle_timeout", {31'd0, busy_a}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stim"}, {24'd0, stim_a}, 32'd0);
    chk({tag, "_valid"}, {31'd0, stim_valid_a}, 32'd0);
    chk({tag, "_genclock"}, {31'd0, genclock_a}, 32'd0);
    chk({tag, "_cycle"}, cycle_a, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
    chk({tag, "_done"}, {31'd0, done_a}, 32'd0);
    chk({tag, "_fail_seen"}, {31'd0, fail_seen_a}, 32'd0);
    chk({tag, "_fail_cycle"}, fail_cycle_a, 32'd0);
  endtask

  // Scoreboard: every live state on dut_a must match the next expected entry.
  always @(posedge clock) begin
    exp_t ent;
    #2;
    if (stim_valid_a) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_stim", {24'd0, stim_a}, 32'hFFFF_FFFF);
      end else begin
        ent = exp_q.pop_front();
        chk("sb_stim", {24'd0, stim_a}, {24'd0, ent.stim});
        chk("sb_cycle", cycle_a, ent.cyc);
        chk("sb_genclock", {31'd0, genclock_a}, 32'd1);
      end
    end
  end

  initial begin
    int bc, dc;
    reset = 1'b1; wr_en = 1'b0; start_a = 1'b0; start_b = 1'b0; loop = 1'b0;
    abort = 1'b0; fail_a = 1'b0; fail_b = 1'b0; wr_addr = 4'd0; wr_data = 8'd0; len = 5'd0;
    step();
    step();
    chk_all_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      mem_m[i] = (i < 4) ? 8'((i + 1) * 8'h11) : 8'(8'h50 + i);
      wr(4'(i), mem_m[i]);
    end

    // Basic replay
    push_run(4, 4);
    start_run(5'd4, 1'b0);
    chk("basic_busy_start", {31'd0, busy_a}, 32'd1);
    run_until_idle(bc, dc);
    chk("basic_busy_cycles", bc, 32'd5);
    chk("basic_done_pulses", dc, 32'd1);
    chk("basic_genclock_after", {31'd0, genclock_a}, 32'd0);

    // len = 0
    start_run(5'd0, 1'b0);
    chk("len0_done", {31'd0, done_a}, 32'd1);
    run_until_idle(bc, dc);
    chk("len0_done_pulses", dc, 32'd1);

    // Loop then abort after eight states
    push_run(8, 3);
    start_run(5'd3, 1'b1);
    for (int i = 0; i < 7; i++) step();
    chk("loop_cycle7", cycle_a, 32'd7);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", {31'd0, stim_valid_a}, 32'd0);
    chk("abort_genclock", {31'd0, genclock_a}, 32'd0);
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    chk("abort_done", {31'd0, done_a}, 32'd0);
    chk("abort_stim_hold", {24'd0, stim_a}, {24'd0, mem_m[1]});
    step();
    chk("abort_no_done", {31'd0, done_a}, 32'd0);

    // len clamp
    push_run(16, 16);
    start_run(5'd31, 1'b0);
    run_until_idle(bc, dc);
    chk("clamp_busy_cycles", bc, 32'd17);
    chk("clamp_done_pulses", dc, 32'd1);

    // start and wr_en during RUN are ignored
    push_run(4, 4);
    start_run(5'd4, 1'b0);
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'hEE; start_a = 1'b1; len = 5'd2;
    step();
    wr_en = 1'b0; start_a = 1'b0;
    run_until_idle(bc, dc);
    chk("ignore_busy_cycles", bc, 32'd4);
    chk("ignore_done_pulses", dc, 32'd1);
    step();
    chk("ignore_no_restart", {31'd0, busy_a}, 32'd0);
    push_run(2, 2);
    start_run(5'd2, 1'b0);
    run_until_idle(bc, dc);

    // Stop on fail at cycle 5
    push_run(6, 8);
    start_run(5'd8, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk("stop_cycle5", cycle_a, 32'd5);
    fail_a = 1'b1;
    step();
    fail_a = 1'b0;
    chk("stop_done", {31'd0, done_a}, 32'd1);
    chk("stop_valid", {31'd0, stim_valid_a}, 32'd0);
    chk("stop_fail_seen", {31'd0, fail_seen_a}, 32'd1);
    chk("stop_fail_cycle", fail_cycle_a, 32'd5);
    step();
    chk("stop_idle", {31'd0, busy_a}, 32'd0);
    chk("stop_fail_cycle_hold", fail_cycle_a, 32'd5);

    // Continue on fail (dut_b), fails at cycles 2 and 6
    len = 5'd8; loop = 1'b0; start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("cont_stim0", {24'd0, stim_b}, {24'd0, mem_m[0]});
    chk("cont_genclock", {31'd0, genclock_b}, 32'd1);
    step(); step();
    chk("cont_cycle2", cycle_b, 32'd2);
    fail_b = 1'b1;
    step();
    fail_b = 1'b0;
    chk("cont_fail_seen", {31'd0, fail_seen_b}, 32'd1);
    chk("cont_fail_cycle_first", fail_cycle_b, 32'd2);
    step(); step(); step();
    chk("cont_cycle6", cycle_b, 32'd6);
    fail_b = 1'b1;
    step();
    fail_b = 1'b0;
    chk("cont_fail_cycle_kept", fail_cycle_b, 32'd2);
    chk("cont_still_running", {31'd0, stim_valid_b}, 32'd1);
    chk("cont_cycle7", cycle_b, 32'd7);
    step();
    chk("cont_done", {31'd0, done_b}, 32'd1);
    step();
    chk("cont_idle", {31'd0, busy_b}, 32'd0);

    // Reset mid-run at cycle 3
    push_run(4, 8);
    start_run(5'd8, 1'b0);
    chk("restart_clears_fail_seen", {31'd0, fail_seen_a}, 32'd0);
    chk("restart_clears_fail_cycle", fail_cycle_a, 32'd0);
    step(); step(); step();
    chk("midrst_cycle3", cycle_a, 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_all_zero("midrst");
    push_run(2, 2);
    start_run(5'd2, 1'b0);
    run_until_idle(bc, dc);
    chk("midrst_rerun_done", dc, 32'd1);

    // Write to address 0 together with start
    mem_m[0] = 8'h99;
    push_run(1, 1);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h99;
    start_run(5'd1, 1'b0);
    wr_en = 1'b0;
    run_until_idle(bc, dc);
    chk("wrstart_busy_cycles", bc, 32'd2);

    step();
    chk("sb_drain", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
